// File: rtl/fft_pkg.sv
// Shared types, sizing constants and the bit-reverse helper for the FFT sequencer.
package fft_pkg;

  localparam int unsigned N2Max     = 12;
  localparam int unsigned N2Default = 5;
  localparam int unsigned NPoints   = 2 ** N2Default;
  localparam int unsigned NHalf     = NPoints / 2;
  localparam int unsigned StageW    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StComp,
    StGap,
    StUnload
  } fft_state_e;

  // Reverse the low n2 bits of v; bits at and above n2 must be zero.
  function automatic logic [N2Max-1:0] bitrev(input logic [N2Max-1:0] v,
                                              input int unsigned n2);
    logic [N2Max-1:0] full;
    for (int unsigned b = 0; b < N2Max; b++) begin
      full[b] = v[N2Max-1-b];
    end
    return full >> (N2Max - n2);
  endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// Handshake and RAM/ROM address bundle between the FFT sequencer and its datapath.
interface fft_sequencer_if
  import fft_pkg::*;
#(
  parameter int unsigned N_2 = N2Default
) ();

  logic           start;
  logic           inverse;
  logic           in_valid;
  logic           in_ready;
  logic           load_we;
  logic [N_2-1:0] load_adr;
  logic           rd_bank;
  logic [N_2-1:0] rd_adra;
  logic [N_2-1:0] rd_adrb;
  logic [N_2-2:0] tw_adr;
  logic           tw_conj;
  logic           wr_en;
  logic           wr_bank;
  logic [N_2-1:0] wr_adra;
  logic [N_2-1:0] wr_adrb;
  logic           out_valid;
  logic           out_ready;
  logic [N_2-1:0] out_adr;
  logic           out_bank;
  logic           out_last;
  logic           busy;
  logic           done;

  modport master (
    input  start, inverse, in_valid, out_ready,
    output in_ready, load_we, load_adr, rd_bank, rd_adra, rd_adrb, tw_adr, tw_conj,
           wr_en, wr_bank, wr_adra, wr_adrb, out_valid, out_adr, out_bank, out_last,
           busy, done
  );

  modport slave (
    output start, inverse, in_valid, out_ready,
    input  in_ready, load_we, load_adr, rd_bank, rd_adra, rd_adrb, tw_adr, tw_conj,
           wr_en, wr_bank, wr_adra, wr_adrb, out_valid, out_adr, out_bank, out_last,
           busy, done
  );

endinterface

// File: rtl/fft_bfly_adr.sv
// Combinational butterfly address generator: (stage, butterfly index) to RAM and twiddle addresses.
module fft_bfly_adr
  import fft_pkg::*;
#(
  parameter int unsigned N_2 = N2Default
) (
  input  logic [StageW-1:0] s,
  input  logic [N_2-2:0]    i,
  output logic [N_2-1:0]    adra,
  output logic [N_2-1:0]    adrb,
  output logic [N_2-2:0]    tw
);

  localparam int unsigned TwW = N_2 - 1;
  localparam logic [N_2-1:0] One = N_2'(1);

  logic [N_2-1:0] iw;
  logic [N_2-1:0] span;
  logic [N_2-1:0] pos;

  always_comb begin
    iw   = {1'b0, i};
    span = One << s;
    pos  = iw & (span - One);
    // Insert a zero at bit s; the partner address sets that bit.
    adra = ((iw >> s) << (s + StageW'(1))) | pos;
    adrb = adra | span;
    tw   = TwW'(pos << (StageW'(N_2 - 1) - s));
  end

endmodule

// File: rtl/fft_sequencer.sv
// Control and address sequencing for an in-place radix-2 DIT FFT over two ping-pong banks.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned N_2 = N2Default
) (
  input  logic            clk,
  input  logic            reset,
  fft_sequencer_if.master bus
);

  localparam logic [N_2-1:0]    LastSample = '1;
  localparam logic [N_2-1:0]    LastBfly   = LastSample >> 1;
  localparam logic [N_2-1:0]    CntOne     = N_2'(1);
  localparam logic [StageW-1:0] LastStage  = StageW'(N_2 - 1);
  localparam logic [StageW-1:0] StageOne   = StageW'(1);
  localparam logic              OutBank    = 1'(N_2 % 2);

  fft_state_e        state_q, state_d;
  logic [N_2-1:0]    cnt_q, cnt_d;
  logic [StageW-1:0] stage_q, stage_d;
  logic              inv_q, inv_d;
  logic              done_q, done_d;

  logic              wr_en_q, wr_bank_q;
  logic [N_2-1:0]    wr_adra_q, wr_adrb_q;

  logic              in_hs, out_hs, rd_en;
  logic [N_2-1:0]    bf_adra, bf_adrb;
  logic [N_2-2:0]    bf_tw;
  logic [N2Max-1:0]  cnt_ext;

  assign in_hs  = (state_q == StLoad) & bus.in_valid;
  assign out_hs = (state_q == StUnload) & bus.out_ready;
  assign rd_en  = (state_q == StComp);

  fft_bfly_adr #(
    .N_2 (N_2)
  ) u_bfly_adr (
    .s    (stage_q),
    .i    (cnt_q[N_2-2:0]),
    .adra (bf_adra),
    .adrb (bf_adrb),
    .tw   (bf_tw)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StLoad;
      StLoad:   if (in_hs && cnt_q == LastSample) state_d = StComp;
      StComp:   if (cnt_q == LastBfly) state_d = StGap;
      StGap:    state_d = (stage_q == LastStage) ? StUnload : StComp;
      StUnload: if (out_hs && cnt_q == LastSample) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Counters, stage index and latched mode.
  always_comb begin
    cnt_d   = cnt_q;
    stage_d = stage_q;
    inv_d   = inv_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        stage_d = '0;
        if (bus.start) inv_d = bus.inverse;
      end
      StLoad: begin
        if (in_hs) cnt_d = cnt_q + CntOne;
      end
      StComp: begin
        cnt_d = (cnt_q == LastBfly) ? '0 : cnt_q + CntOne;
      end
      StGap: begin
        stage_d = (stage_q == LastStage) ? '0 : stage_q + StageOne;
      end
      StUnload: begin
        if (out_hs) begin
          cnt_d = cnt_q + CntOne;
          if (cnt_q == LastSample) begin
            done_d = 1'b1;
            inv_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  // Write side lags reads by one cycle to line up with the registered twiddle ROM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_adra_q <= '0;
      wr_adrb_q <= '0;
    end else begin
      wr_en_q   <= rd_en;
      wr_bank_q <= rd_en & ~stage_q[0];
      wr_adra_q <= rd_en ? bf_adra : '0;
      wr_adrb_q <= rd_en ? bf_adrb : '0;
    end
  end

  assign cnt_ext = {{(N2Max - 1){1'b0}}, 1'b0} | N2Max'(cnt_q);

  // Output decode.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.load_we   = 1'b0;
    bus.load_adr  = '0;
    bus.rd_bank   = 1'b0;
    bus.rd_adra   = '0;
    bus.rd_adrb   = '0;
    bus.tw_adr    = '0;
    bus.out_valid = 1'b0;
    bus.out_adr   = '0;
    bus.out_bank  = 1'b0;
    bus.out_last  = 1'b0;
    unique case (state_q)
      StLoad: begin
        bus.in_ready = 1'b1;
        bus.load_we  = bus.in_valid;
        bus.load_adr = N_2'(bitrev(cnt_ext, N_2));
      end
      StComp: begin
        bus.rd_bank = stage_q[0];
        bus.rd_adra = bf_adra;
        bus.rd_adrb = bf_adrb;
        bus.tw_adr  = bf_tw;
      end
      StUnload: begin
        bus.out_valid = 1'b1;
        bus.out_adr   = cnt_q;
        bus.out_bank  = OutBank;
        bus.out_last  = (cnt_q == LastSample);
      end
      default: ;
    endcase
  end

  assign bus.tw_conj = inv_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_bank = wr_bank_q;
  assign bus.wr_adra = wr_adra_q;
  assign bus.wr_adrb = wr_adrb_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Parametrised control and address-generation unit for the in-place radix-2 DIT FFT datapath: butterfly, twiddle ROM and two ping-pong two-port RAM banks. It sequences a full transform through three phases: bit-reversed sample load, N_2 butterfly stages alternating between banks, and natural-order result unload. Both load and unload use valid/ready handshakes. The block adds a runtime inverse-transform mode and a pipelined write path that matches the registered twiddle ROM.

## Interface
- N_2, 5: log2 of point count N; legal range 2..12.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start  in  1  begin transform; honoured only in IDLE.
- inverse  in  1  sampled with accepted start; selects IFFT.
- in_valid  in  1  load sample present.
- in_ready  out  1  high throughout LOAD.
- load_we  out  1  = in_valid & in_ready; writes bank 0.
- load_adr  out  N_2  bit-reverse of load count.
- rd_bank  out  1  bank feeding butterfly.
- rd_adra, rd_adrb  out  N_2 each  butterfly read addresses.
- tw_adr  out  N_2-1  twiddle ROM address.
- tw_conj  out  1  latched inverse; datapath conjugates twiddle.
- wr_en  out  1  butterfly write strobe.
- wr_bank  out  1  = ~rd_bank of the issuing cycle.
- wr_adra, wr_adrb  out  N_2 each  write addresses.
- out_valid  out  1  result available during UNLOAD.
- out_ready  in  1  consumer accepts.
- out_adr  out  N_2  natural-order read address into final bank.
- out_bank  out  1  = N_2 mod 2.
- out_last  out  1  out_adr == N-1 while out_valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after last unload handshake.

## Operation
- States:
  - IDLE→LOAD on start.
  - LOAD→COMP after N accepted samples.
  - COMP→GAP after last butterfly of a stage.
  - GAP→COMP (next stage) or →UNLOAD after stage N_2-1.
  - UNLOAD→IDLE on handshake with out_last; done asserts in the IDLE cycle that follows.
- LOAD: counter k advances on in_valid only; load_adr = bitrev(k). in_valid low stalls indefinitely.
- COMP, stage s (0..N_2-1), butterfly i (0..N/2-1), one per cycle, no stalls:
  - span = 2^s; pos = i & (span-1).
  - rd_adra = ((i>>s)<<(s+1)) | pos; rd_adrb = rd_adra + span.
  - tw_adr = pos << (N_2-1-s).
  - rd_bank = s mod 2.
- Write path: wr_en/wr_adra/wr_adrb/wr_bank are the read-side values registered one cycle, so the write aligns with the registered twiddle ROM.
- GAP: one bubble cycle per stage. No read is issued; the delayed write of the stage's last butterfly retires. This removes the read-after-write hazard across stages.
- UNLOAD: out_adr advances only on out_valid & out_ready. out_adr, out_valid and out_last hold stable while out_ready is low.
- start while busy is ignored; inverse is not re-sampled.
- Counters wrap to 0 on phase exit. No partial state survives into the next transform.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - counters 0;
  - latched inverse 0.
- Reset mid-transform aborts immediately. RAM contents are undefined afterwards; a new start is required.
- Latency, start to first in_ready: 1 cycle.
- COMP+GAP duration: N_2·(N/2+1) cycles, exactly.
- wr_en trails the matching rd_adra by exactly 1 cycle. The first wr_en of a stage falls in its second cycle; the last falls in GAP.
- done pulse: 1 cycle after the final out handshake.
- Minimum transform length: N + N_2·(N/2+1) + N cycles, with no backpressure.

## Structure
- Package fft_pkg holds:
  - state enum (IDLE, LOAD, COMP, GAP, UNLOAD);
  - bitrev function parametrised by N_2;
  - N = 2**N_2 and N/2 constants.
- One sub-module, fft_bfly_adr: combinational (s, i) → rd_adra, rd_adrb, tw_adr. It is reused by the bench's reference model.

## Test plan
- Reset asserted, then released with start=0 → every output 0, busy=0 for 10 cycles.
- N_2=3; start, then 8 samples with in_valid held → load_adr sequence 0,4,2,6,1,5,3,7; in_ready drops after the 8th.
- N_2=3 COMP checks:
  - s=0, i=2 → adra 4, adrb 5, tw 0;
  - s=1, i=1 → adra 1, adrb 3, tw 2;
  - s=2, i=3 → adra 3, adrb 7, tw 3;
  - rd_bank 0,1,0; out_bank 1; COMP+GAP = 15 cycles; wr_* equals rd_* delayed by 1.
- UNLOAD with out_ready low 3 cycles at out_adr 5 → out_adr holds 5. out_last at 7. done pulses once, 1 cycle after the 8th handshake.
- start with inverse=1, inverse toggled mid-COMP → tw_conj stays 1 throughout. A second start while busy → no effect.
- reset pulsed during stage 1 of COMP → all outputs 0 asynchronously. A subsequent full transform matches the reference model.
